// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV64I integer decode stage with decoded-bundle buffer
//
// Decodes OP, OP-IMM, OP-32, OP-IMM-32 and LUI into ALU control plus a
// sign-extended immediate, then queues the decoded bundle in a DEPTH-entry FIFO
// that absorbs execute back-pressure.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 drop buffered bundles and the concurrent input
//   in_valid/in_ready     fetch handshake; in_instr, in_pc carry the instruction
//   out_valid/out_ready   execute handshake; out_* describe the head bundle
//   out_aluop             0 ADD,1 SUB,2 XOR,3 OR,4 AND,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 PASSB
//   illegal_cnt           saturating count of accepted illegal instructions
module decode_stage #(
  parameter int XLEN            = 64,
  parameter int DEPTH           = 2,
  parameter int ENABLE_WORD_OPS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_aluop,
  output logic             out_alusrc,
  output logic             out_word,
  output logic             out_reg_write,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR = 4'd3,
                         OP_AND = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_PASSB = 4'd10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      aluop;
    logic            alusrc;
    logic            word;
    logic            reg_write;
    logic            illegal;
  } bundle_t;

  bundle_t          mem_q [DEPTH];
  bundle_t          mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  bundle_t          dec;
  logic             push, pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Combinational decode of the incoming instruction.
  always_comb begin
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i, imm_u;
    logic        bad;
    dec     = '0;
    opcode  = in_instr[6:0];
    funct3  = in_instr[14:12];
    funct7  = in_instr[31:25];
    // Build immediates at 64 bits and truncate, so XLEN=32 needs no special case.
    imm_i   = {{52{in_instr[31]}}, in_instr[31:20]};
    imm_u   = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
    bad     = 1'b0;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.aluop = OP_ADD;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.aluop = OP_ADD;
            3'b001:  dec.aluop = OP_SLL;
            3'b010:  dec.aluop = OP_SLT;
            3'b011:  dec.aluop = OP_SLTU;
            3'b100:  dec.aluop = OP_XOR;
            3'b101:  dec.aluop = OP_SRL;
            3'b110:  dec.aluop = OP_OR;
            default: dec.aluop = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.aluop = OP_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.aluop = OP_SRA;
        else bad = 1'b1;
      end
      7'b0010011: begin
        dec.alusrc = 1'b1;
        dec.imm    = imm_i[XLEN-1:0];
        case (funct3)
          3'b000: dec.aluop = OP_ADD;
          3'b010: dec.aluop = OP_SLT;
          3'b011: dec.aluop = OP_SLTU;
          3'b100: dec.aluop = OP_XOR;
          3'b110: dec.aluop = OP_OR;
          3'b111: dec.aluop = OP_AND;
          3'b001: begin
            if (in_instr[31:26] == 6'b000000) dec.aluop = OP_SLL;
            else bad = 1'b1;
          end
          default: begin
            if (in_instr[31:26] == 6'b000000) dec.aluop = OP_SRL;
            else if (in_instr[31:26] == 6'b010000) begin
              // Strip the funct6 marker so the immediate is the bare shamt.
              dec.aluop = OP_SRA;
              dec.imm   = XLEN'(in_instr[25:20]);
            end else bad = 1'b1;
          end
        endcase
      end
      7'b0111011: begin
        dec.word = 1'b1;
        if (ENABLE_WORD_OPS == 0) bad = 1'b1;
        else if (funct7 == 7'b0000000 && funct3 == 3'b000) dec.aluop = OP_ADD;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.aluop = OP_SUB;
        else if (funct7 == 7'b0000000 && funct3 == 3'b001) dec.aluop = OP_SLL;
        else if (funct7 == 7'b0000000 && funct3 == 3'b101) dec.aluop = OP_SRL;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.aluop = OP_SRA;
        else bad = 1'b1;
      end
      7'b0011011: begin
        dec.word   = 1'b1;
        dec.alusrc = 1'b1;
        dec.imm    = imm_i[XLEN-1:0];
        if (ENABLE_WORD_OPS == 0) bad = 1'b1;
        else if (funct3 == 3'b000) dec.aluop = OP_ADD;
        else if (funct7 == 7'b0000000 && funct3 == 3'b001) dec.aluop = OP_SLL;
        else if (funct7 == 7'b0000000 && funct3 == 3'b101) dec.aluop = OP_SRL;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.aluop = OP_SRA;
          dec.imm   = XLEN'(in_instr[24:20]);
        end else bad = 1'b1;
      end
      7'b0110111: begin
        dec.aluop  = OP_PASSB;
        dec.alusrc = 1'b1;
        dec.imm    = imm_u[XLEN-1:0];
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.aluop  = OP_ADD;
      dec.alusrc = 1'b0;
      dec.word   = 1'b0;
      dec.imm    = '0;
    end
    dec.illegal   = bad;
    dec.reg_write = !bad && (dec.rd != 5'd0);
  end

  // Full is judged on the registered count, so a pop never re-opens accept in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wrap_inc(wr_ptr_q);
        if (dec.illegal && illegal_cnt_q != {CNT_W{1'b1}})
          illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
      if (pop) rd_ptr_d = wrap_inc(rd_ptr_q);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign out_pc        = mem_q[rd_ptr_q].pc;
  assign out_rd        = mem_q[rd_ptr_q].rd;
  assign out_rs1       = mem_q[rd_ptr_q].rs1;
  assign out_rs2       = mem_q[rd_ptr_q].rs2;
  assign out_imm       = mem_q[rd_ptr_q].imm;
  assign out_aluop     = mem_q[rd_ptr_q].aluop;
  assign out_alusrc    = mem_q[rd_ptr_q].alusrc;
  assign out_word      = mem_q[rd_ptr_q].word;
  assign out_reg_write = mem_q[rd_ptr_q].reg_write;
  assign out_illegal   = mem_q[rd_ptr_q].illegal;
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        in_ready, out_valid, out_alusrc, out_word, out_reg_write, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  out_aluop;
  logic [15:0] illegal_cnt;

  logic        nw_in_valid, nw_in_ready, nw_out_valid, nw_alusrc, nw_word, nw_reg_write, nw_illegal;
  logic [63:0] nw_out_pc, nw_imm;
  logic [4:0]  nw_rd, nw_rs1, nw_rs2;
  logic [3:0]  nw_aluop;
  logic [15:0] nw_illegal_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_aluop(out_aluop), .out_alusrc(out_alusrc), .out_word(out_word),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  decode_stage #(.ENABLE_WORD_OPS(0)) dut_nw (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(nw_in_valid), .in_ready(nw_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(nw_out_valid), .out_ready(1'b1), .out_pc(nw_out_pc),
    .out_rd(nw_rd), .out_rs1(nw_rs1), .out_rs2(nw_rs2), .out_imm(nw_imm),
    .out_aluop(nw_aluop), .out_alusrc(nw_alusrc), .out_word(nw_word),
    .out_reg_write(nw_reg_write), .out_illegal(nw_illegal), .illegal_cnt(nw_illegal_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; nw_in_valid = 1'b0;
    out_ready = 1'b1; in_instr = 32'h0; in_pc = 64'h0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_imm !== 64'h0 || out_pc !== 64'h0) begin errors++; $display("FAIL reset_data got imm=%h pc=%h want 0", out_imm, out_pc); end
    checks++; if (illegal_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", illegal_cnt); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h1000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", out_valid); end
    checks++; if (out_aluop !== 4'd0 || out_imm !== 64'd5 || out_rd !== 5'd1) begin
      errors++; $display("FAIL addi_fields got aluop=%0d imm=%h rd=%0d want 0/5/1", out_aluop, out_imm, out_rd); end
    checks++; if (out_alusrc !== 1'b1 || out_reg_write !== 1'b1 || out_pc !== 64'h1000) begin
      errors++; $display("FAIL addi_ctrl got alusrc=%0b wr=%0b pc=%h want 1/1/1000", out_alusrc, out_reg_write, out_pc); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_pop got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = 32'h40208133; in_pc = 64'h2000;
    step();
    checks++; if (out_aluop !== 4'd1 || out_rd !== 5'd2 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_alusrc !== 1'b0) begin
      errors++; $display("FAIL sub_fields got aluop=%0d rd=%0d rs1=%0d rs2=%0d src=%0b want 1/2/1/2/0", out_aluop, out_rd, out_rs1, out_rs2, out_alusrc); end
    in_instr = 32'hFFF0C193; in_pc = 64'h2004;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h2004) begin errors++; $display("FAIL xori_order got valid=%0b pc=%h want 1/2004", out_valid, out_pc); end
    checks++; if (out_aluop !== 4'd2 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_rd !== 5'd3) begin
      errors++; $display("FAIL xori_fields got aluop=%0d imm=%h rd=%0d want 2/ffffffffffffffff/3", out_aluop, out_imm, out_rd); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h100;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_one_ready got %0b want 1", in_ready); end
    in_instr = 32'h00200113; in_pc = 64'h104;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %0b want 0", in_ready); end
    in_instr = 32'h00300193; in_pc = 64'h108;
    step();
    checks++; if (in_ready !== 1'b0 || out_pc !== 64'h100 || out_imm !== 64'd1 || out_rd !== 5'd1) begin
      errors++; $display("FAIL bp_stall got ready=%0b pc=%h imm=%h rd=%0d want 0/100/1/1", in_ready, out_pc, out_imm, out_rd); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 64'h104 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_pop1 got pc=%h ready=%0b valid=%0b want 104/1/1", out_pc, in_ready, out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 64'h108 || out_imm !== 64'd3 || out_rd !== 5'd3) begin
      errors++; $display("FAIL bp_pop2 got pc=%h imm=%h rd=%0d want 108/3/3", out_pc, out_imm, out_rd); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_word_ops();
    in_valid = 1'b1; nw_in_valid = 1'b1; in_instr = 32'h4030D21B; in_pc = 64'h300;
    step();
    in_valid = 1'b0; nw_in_valid = 1'b0;
    checks++; if (out_word !== 1'b1 || out_aluop !== 4'd7 || out_imm !== 64'd3 || out_rd !== 5'd4 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL sraiw got word=%0b aluop=%0d imm=%h rd=%0d ill=%0b want 1/7/3/4/0", out_word, out_aluop, out_imm, out_rd, out_illegal); end
    checks++; if (nw_illegal !== 1'b1 || nw_reg_write !== 1'b0 || nw_aluop !== 4'd0 || nw_out_valid !== 1'b1) begin
      errors++; $display("FAIL sraiw_nowords got ill=%0b wr=%0b aluop=%0d valid=%0b want 1/0/0/1", nw_illegal, nw_reg_write, nw_aluop, nw_out_valid); end
    checks++; if (nw_illegal_cnt !== 16'd1 || illegal_cnt !== 16'd0) begin
      errors++; $display("FAIL word_cnt got nw=%0d main=%0d want 1/0", nw_illegal_cnt, illegal_cnt); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h400;
    step(); step();
    in_instr = 32'hFFFFFFFF; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 16'd0) begin
      errors++; $display("FAIL flush_full got valid=%0b ready=%0b cnt=%0d want 0/1/0", out_valid, in_ready, illegal_cnt); end
    in_valid = 1'b1; in_instr = 32'h00100093;
    step();
    in_instr = 32'hFFFFFFFF; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || illegal_cnt !== 16'd0) begin
      errors++; $display("FAIL flush_open got valid=%0b cnt=%0d want 0/0", out_valid, illegal_cnt); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_aluop !== 4'd0 || illegal_cnt !== 16'd1) begin
      errors++; $display("FAIL illegal_push got ill=%0b wr=%0b aluop=%0d cnt=%0d want 1/0/0/1", out_illegal, out_reg_write, out_aluop, illegal_cnt); end
    step();
  endtask

  task automatic test_misc_and_reset();
    in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 64'h500;
    step();
    checks++; if (out_reg_write !== 1'b0 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL nop_rd0 got wr=%0b ill=%0b want 0/0", out_reg_write, out_illegal); end
    in_instr = 32'h123452B7;
    step();
    checks++; if (out_imm !== 64'h12345000 || out_aluop !== 4'd10 || out_rd !== 5'd5 || out_alusrc !== 1'b1) begin
      errors++; $display("FAIL lui got imm=%h aluop=%0d rd=%0d src=%0b want 12345000/10/5/1", out_imm, out_aluop, out_rd, out_alusrc); end
    in_instr = 32'h800002B7;
    step();
    checks++; if (out_imm !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui_neg got %h want ffffffff80000000", out_imm); end
    in_instr = 32'h4050D093;
    step();
    checks++; if (out_aluop !== 4'd7 || out_imm !== 64'd5 || out_word !== 1'b0) begin
      errors++; $display("FAIL srai got aluop=%0d imm=%h word=%0b want 7/5/0", out_aluop, out_imm, out_word); end
    out_ready = 1'b0;
    in_instr = 32'h00100093;
    step(); step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 16'd0 || out_pc !== 64'h0) begin
      errors++; $display("FAIL midreset got valid=%0b ready=%0b cnt=%0d pc=%h want 0/1/0/0", out_valid, in_ready, illegal_cnt, out_pc); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_word_ops();
    test_flush();
    test_misc_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
